branch_result_queue: RTL and testbench
======================================

Name: branch_result_queue

Overview:
Parametrised branch-resolution control block that classifies resolved branches into taken/not-taken and good/mispredicted results. It buffers up to DEPTH tagged results in a FIFO, with a valid/ready handshake on both sides. It sits between the branch unit datapath (comparator and target check) and the commit/redirect logic. It blocks wrong-path branches after a mispredict and supports a synchronous pipeline flush.

Parameters:
DEPTH, 4, result FIFO entries; power of two, >= 2
TAG_W, 3, width of branch tag carried with each result

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous, active-low
ops_valid_i  in  1  resolved-branch operands valid
ops_ready_o  out  1  block can accept a branch this cycle
ops_tag_i  in  TAG_W  tag of incoming branch
taken_i  in  1  branch actually taken
wrong_taken_i  in  1  taken/not-taken prediction was wrong
wrong_target_i  in  1  predicted target was wrong (meaningful only if taken_i)
flush_i  in  1  synchronous flush of all buffered results
res_valid_o  out  1  head result valid
res_ready_i  in  1  consumer accepts head result
res_tag_o  out  TAG_W  head tag
res_taken_o  out  1  head branch taken
res_mispredict_o  out  1  head branch mispredicted
count_o  out  $clog2(DEPTH+1)  number of buffered results

Behaviour:
- Reset: clk_i with rst_n_i, asynchronous, active-low. During and after reset: state=RESET, count_o=0, ops_ready_o=0, res_valid_o=0, res_tag_o=0, res_taken_o=0, res_mispredict_o=0, FIFO pointers=0.
- Classification at enqueue:
  - mispredict = taken_i ? (wrong_taken_i | wrong_target_i) : wrong_taken_i.
  - The stored taken bit is taken_i.
  - wrong_target_i is ignored when taken_i=0.
- Enqueue occurs when ops_valid_i & ops_ready_o & !flush_i. The entry is written at the tail and is visible at the head output no earlier than the next cycle; there is no input-to-output combinational path.
- Dequeue occurs when res_valid_o & res_ready_i & !flush_i.
  - res_valid_o = (count != 0).
  - res_* come from the head entry. While res_valid_o=1 and res_ready_i=0 they are held stable.
- Enqueue and dequeue may happen in the same cycle; count is unchanged in that case. Pointers wrap modulo DEPTH.
- FSM:
  - RESET: ops_ready_o=0. Always moves to RUN on the next cycle.
  - RUN: ops_ready_o = (count < DEPTH). An enqueue with mispredict=1 moves to BLOCKED.
  - BLOCKED: ops_ready_o=0, so no wrong-path branch is accepted. The mispredicted entry is always the youngest. Dequeue of an entry with mispredict=1 moves to RUN; ops_ready_o rises the following cycle.
  - flush_i=1 in RUN or BLOCKED moves to RUN.
- Flush:
  - In the cycle after flush_i=1: count=0, pointers=0, res_valid_o=0.
  - Flush has priority over a simultaneous enqueue or dequeue. An operand handshake completing in a flush cycle is dropped, and so is a result handshake in that cycle; neither is counted.
  - flush_i has no effect in RESET.
- Full: when count=DEPTH, ops_ready_o=0, including in a cycle where a dequeue occurs. Space is seen the following cycle.
- Empty: res_valid_o=0 and res_* hold their last driven values. The consumer must ignore them.
- Reset asserted mid-operation discards all entries immediately (asynchronous) and returns to RESET.
- ops_ready_o and res_valid_o depend only on registered state. They have no combinational dependence on ops_valid_i or res_ready_i.

Test Plan:
- Reset, then ops_valid_i=1, tag=2, taken=1, both wrong=0 -> ops_ready_o=0 for the first cycle after reset release. The branch is accepted the next cycle. One cycle later: res_valid_o=1, tag=2, taken=1, mispredict=0, count_o=1.
- DEPTH=4, res_ready_i=0, push tags 0..4 with no mispredicts -> tags 0..3 accepted and ops_ready_o=0 at count_o=4. Raising res_ready_i pops 0,1,2,3 in order. Tag 4 is accepted once count_o<4 is registered.
- Push taken=0, wrong_taken=0, wrong_target=1 -> mispredict=0. Push taken=1, wrong_target=1 -> mispredict=1, BLOCKED, ops_ready_o=0. ops_ready_o stays 0 until that entry is popped, and is 1 the cycle after.
- 3 entries buffered, BLOCKED, flush_i=1 together with ops_valid_i=1 and res_ready_i=1 -> next cycle count_o=0, res_valid_o=0, state RUN, ops_ready_o=1. Neither handshake is recorded.
- Steady stream at count_o=2 with ops_valid_i=1 and res_ready_i=1 for 10 cycles, tags 0..7 wrapping -> count_o stays 2. Results emerge in order, 2 cycles behind, across pointer wrap.
- rst_n_i asserted mid-stream with 3 entries -> all outputs 0 immediately, without waiting for a clock edge. After release, one RESET cycle, then count_o=0 with no stale entries.

Source files
------------

// File: rtl/branch_result_queue.sv
// Branch result queue: classifies resolved branches as taken/mispredicted and buffers them
// in a small FIFO. After a mispredict, input is blocked until that entry is consumed.
module branch_result_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       ops_valid_i,
  output logic                       ops_ready_o,
  input  logic [TAG_W-1:0]           ops_tag_i,
  input  logic                       taken_i,
  input  logic                       wrong_taken_i,
  input  logic                       wrong_target_i,
  input  logic                       flush_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic [TAG_W-1:0]           res_tag_o,
  output logic                       res_taken_o,
  output logic                       res_mispredict_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  localparam logic [1:0] StReset   = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StBlocked = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [TAG_W-1:0] tag_mem_q [DEPTH];
  logic [DEPTH-1:0] taken_mem_q;
  logic [DEPTH-1:0] misp_mem_q;

  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             res_taken_q, res_taken_d;
  logic             res_misp_q, res_misp_d;

  logic in_misp, flush_act, enq, deq;

  // wrong_target_i only matters for taken branches
  assign in_misp   = wrong_taken_i | (taken_i & wrong_target_i);
  assign flush_act = flush_i & (state_q != StReset);

  assign ops_ready_o = (state_q == StRun) && (count_q != CntFull);
  assign res_valid_o = (count_q != '0);

  assign enq = ops_valid_i & ops_ready_o & ~flush_i;
  assign deq = res_valid_o & res_ready_i & ~flush_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:   state_d = StRun;
      StRun: begin
        if (flush_act)           state_d = StRun;
        else if (enq && in_misp) state_d = StBlocked;
      end
      StBlocked: begin
        if (flush_act)                      state_d = StRun;
        else if (deq && misp_mem_q[rd_ptr_q]) state_d = StRun;
      end
      default:   state_d = StReset;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_act) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Head outputs are registered; when the FIFO goes empty they keep their last value.
  always_comb begin
    res_tag_d   = res_tag_q;
    res_taken_d = res_taken_q;
    res_misp_d  = res_misp_q;
    if (count_d != '0) begin
      if (enq && (wr_ptr_q == rd_ptr_d)) begin
        res_tag_d   = ops_tag_i;
        res_taken_d = taken_i;
        res_misp_d  = in_misp;
      end else begin
        res_tag_d   = tag_mem_q[rd_ptr_d];
        res_taken_d = taken_mem_q[rd_ptr_d];
        res_misp_d  = misp_mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StReset;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      res_tag_q   <= '0;
      res_taken_q <= 1'b0;
      res_misp_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      res_tag_q   <= res_tag_d;
      res_taken_q <= res_taken_d;
      res_misp_q  <= res_misp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      tag_mem_q[wr_ptr_q]   <= ops_tag_i;
      taken_mem_q[wr_ptr_q] <= taken_i;
      misp_mem_q[wr_ptr_q]  <= in_misp;
    end
  end

  assign res_tag_o        = res_tag_q;
  assign res_taken_o      = res_taken_q;
  assign res_mispredict_o = res_misp_q;
  assign count_o          = count_q;

endmodule

// File: tb/tb_branch_result_queue.sv
// Randomised and directed bench for branch_result_queue against a queue-based reference model.
module tb_branch_result_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 3;
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b0;
  logic             ops_valid_i = 1'b0;
  logic             ops_ready_o;
  logic [TAG_W-1:0] ops_tag_i = '0;
  logic             taken_i = 1'b0;
  logic             wrong_taken_i = 1'b0;
  logic             wrong_target_i = 1'b0;
  logic             flush_i = 1'b0;
  logic             res_valid_o;
  logic             res_ready_i = 1'b0;
  logic [TAG_W-1:0] res_tag_o;
  logic             res_taken_o;
  logic             res_mispredict_o;
  logic [CntW-1:0]  count_o;

  branch_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .ops_valid_i      (ops_valid_i),
    .ops_ready_o      (ops_ready_o),
    .ops_tag_i        (ops_tag_i),
    .taken_i          (taken_i),
    .wrong_taken_i    (wrong_taken_i),
    .wrong_target_i   (wrong_target_i),
    .flush_i          (flush_i),
    .res_valid_o      (res_valid_o),
    .res_ready_i      (res_ready_i),
    .res_tag_o        (res_tag_o),
    .res_taken_o      (res_taken_o),
    .res_mispredict_o (res_mispredict_o),
    .count_o          (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             tk;
    logic             mp;
  } ent_t;

  // Model state: 0 = reset cycle, 1 = accepting, 2 = blocked behind a mispredict
  ent_t mq[$];
  int   mst;
  int   n_vec;
  int   n_err;

  function automatic bit m_ready();
    return (mst == 1) && (mq.size() < DEPTH);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clock();
    bit   rdy, vld, enq, deq;
    ent_t e, h;
    rdy = m_ready();
    vld = mq.size() != 0;
    if (mst == 0) begin
      mst = 1;
    end else if (flush_i) begin
      mq.delete();
      mst = 1;
    end else begin
      enq = ops_valid_i && rdy;
      deq = vld && res_ready_i;
      if (deq) begin
        h = mq.pop_front();
        if (mst == 2 && h.mp) mst = 1;
      end
      if (enq) begin
        e.tag = ops_tag_i;
        e.tk  = taken_i;
        e.mp  = taken_i ? (wrong_taken_i | wrong_target_i) : wrong_taken_i;
        mq.push_back(e);
        if (e.mp) mst = 2;
      end
    end
  endtask

  task automatic compare();
    chk("ops_ready", int'(ops_ready_o), int'(m_ready()));
    chk("res_valid", int'(res_valid_o), int'(mq.size() != 0));
    chk("count", int'(count_o), mq.size());
    if (mq.size() != 0) begin
      chk("res_tag", int'(res_tag_o), int'(mq[0].tag));
      chk("res_taken", int'(res_taken_o), int'(mq[0].tk));
      chk("res_misp", int'(res_mispredict_o), int'(mq[0].mp));
    end
  endtask

  task automatic cyc(input logic v, input logic [TAG_W-1:0] tg, input logic tk,
                     input logic wt, input logic wg, input logic fl, input logic rr);
    ops_valid_i    = v;
    ops_tag_i      = tg;
    taken_i        = tk;
    wrong_taken_i  = wt;
    wrong_target_i = wg;
    flush_i        = fl;
    res_ready_i    = rr;
    @(posedge clk_i);
    model_clock();
    @(negedge clk_i);
    compare();
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    #1;
    chk("rst_ready", int'(ops_ready_o), 0);
    chk("rst_valid", int'(res_valid_o), 0);
    chk("rst_count", int'(count_o), 0);
    chk("rst_tag", int'(res_tag_o), 0);
    chk("rst_taken", int'(res_taken_o), 0);
    chk("rst_misp", int'(res_mispredict_o), 0);
    mq.delete();
    mst = 0;
    ops_valid_i = 1'b0;
    flush_i     = 1'b0;
    res_ready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    compare();
  endtask

  initial begin
    int k;
    n_vec = 0;
    n_err = 0;
    mst   = 0;
    @(negedge clk_i);
    do_reset();

    // First cycle after release is the reset state; accept happens one cycle later
    chk("t1_ready0", int'(ops_ready_o), 0);
    cyc(1, 3'd2, 1, 0, 0, 0, 0);
    chk("t1_ready1", int'(ops_ready_o), 1);
    cyc(1, 3'd2, 1, 0, 0, 0, 0);
    chk("t1_valid", int'(res_valid_o), 1);
    chk("t1_tag", int'(res_tag_o), 2);
    chk("t1_taken", int'(res_taken_o), 1);
    chk("t1_misp", int'(res_mispredict_o), 0);
    chk("t1_count", int'(count_o), 1);

    // Fill to DEPTH with consumer stalled, then drain
    cyc(0, 0, 0, 0, 0, 1, 0);
    k = 0;
    for (int i = 0; i < 6; i++) begin
      bit r;
      r = m_ready();
      cyc(1, TAG_W'(k), 0, 0, 0, 0, 0);
      if (r) k++;
    end
    chk("full_count", int'(count_o), 4);
    chk("full_ready", int'(ops_ready_o), 0);
    chk("full_head", int'(res_tag_o), 0);
    for (int i = 0; i < 7; i++) begin
      bit r;
      r = m_ready();
      cyc(k < 5, TAG_W'(k), 0, 0, 0, 0, 1);
      if (r && k < 5) k++;
    end

    // wrong_target ignored when not taken; taken + wrong target blocks
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(1, 3'd5, 0, 0, 1, 0, 0);
    chk("nt_misp", int'(res_mispredict_o), 0);
    cyc(1, 3'd6, 1, 0, 1, 0, 0);
    chk("blk_ready", int'(ops_ready_o), 0);
    for (int i = 0; i < 3; i++) cyc(1, 3'd7, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 3'd7, 1, 0, 0, 0, 1);

    // Flush while blocked with 3 entries, both handshakes offered
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(1, 3'd1, 0, 0, 0, 0, 0);
    cyc(1, 3'd2, 1, 0, 0, 0, 0);
    cyc(1, 3'd3, 0, 1, 0, 0, 0);
    chk("pre_fl_count", int'(count_o), 3);
    cyc(1, 3'd4, 1, 0, 0, 1, 1);
    chk("fl_count", int'(count_o), 0);
    chk("fl_valid", int'(res_valid_o), 0);
    chk("fl_ready", int'(ops_ready_o), 1);

    // Steady stream at occupancy 2 across pointer wrap
    k = 0;
    cyc(1, TAG_W'(k), 1, 0, 0, 0, 0); k++;
    cyc(1, TAG_W'(k), 0, 0, 0, 0, 0); k++;
    for (int i = 0; i < 10; i++) begin
      cyc(1, TAG_W'(k), k[0], 0, 0, 0, 1);
      k++;
      chk("stream_count", int'(count_o), 2);
    end

    // Asynchronous reset with 3 entries in flight
    cyc(1, 3'd1, 0, 0, 0, 0, 0);
    chk("pre_rst_count", int'(count_o), 3);
    #2;
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_count", int'(count_o), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, TAG_W'($urandom), $urandom_range(0, 1),
          $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 24) == 0, $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
